// File: rtl/reward_mem.sv
// Reward stage: fetches the neighbour record of the rewarded next hop from a
// byte-wide preloadable memory and produces the saturated updated Q-value.
module reward_mem (
    input  logic        clock,
    input  logic        nreset,
    input  logic [15:0] _action,
    input  logic [15:0] _besthop,
    input  logic [15:0] MY_NODE_ID,
    input  logic [15:0] MY_CLUSTER_ID,
    input  logic        done_prev,
    input  logic        wr_en,
    input  logic [9:0]  wr_addr,
    input  logic [15:0] mem_data_in,
    output logic [15:0] address,
    output logic        done_reward,
    output logic [15:0] new_data_out
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        A_CLUS = 3'd1,
        A_HOPS = 3'd2,
        A_Q    = 3'd3,
        CALC   = 3'd4,
        DONE   = 3'd5
    } state_t;

    logic [7:0]  mem [1024];

    state_t      state_q, state_d;
    logic [15:0] act_q, act_d;
    logic [15:0] best_q, best_d;
    logic [15:0] node_q, node_d;
    logic [15:0] clus_id_q, clus_id_d;
    logic [9:0]  addr_q, addr_d;
    logic [15:0] rd_q, rd_d;
    logic [15:0] nbr_clus_q, nbr_clus_d;
    logic [15:0] hops_q, hops_d;
    logic        done_q, done_d;
    logic [15:0] data_q, data_d;

    logic [2:0]  bonus_s;
    logic [17:0] r_wide_s;
    logic [15:0] reward_s;
    logic [17:0] sum_s;
    logic [15:0] result_s;
    logic [9:0]  base_s;

    function automatic logic [9:0] base_addr(input logic [15:0] n);
        return 10'h100 + {n[6:0], 3'b000};
    endfunction

    // Clamp an 18-bit two's complement value into the signed 16-bit range.
    function automatic logic [15:0] sat16(input logic [17:0] v);
        logic [15:0] r;
        if (!v[17] && (v[16:15] != 2'b00)) begin
            r = 16'h7FFF;
        end else if (v[17] && (v[16:15] != 2'b11)) begin
            r = 16'h8000;
        end else begin
            r = v[15:0];
        end
        return r;
    endfunction

    // Preload port; memory is deliberately outside the reset domain.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr]          <= mem_data_in[7:0];
            mem[wr_addr + 10'd1]  <= mem_data_in[15:8];
        end
    end

    // Reward and saturated Q update from the latched record fields.
    always_comb begin
        bonus_s  = (act_q == best_q ? 3'd4 : 3'd0) + (nbr_clus_q == clus_id_q ? 3'd2 : 3'd0);
        r_wide_s = {15'd0, bonus_s} - {2'b00, hops_q};
        if (act_q == node_q) begin
            reward_s = 16'hFFF0;
        end else begin
            reward_s = sat16(r_wide_s);
        end
        sum_s    = {{2{rd_q[15]}}, rd_q} + {{2{reward_s[15]}}, reward_s};
        result_s = sat16(sum_s);
    end

    // Next-state, address sequencing and operand capture.
    always_comb begin
        state_d    = state_q;
        act_d      = act_q;
        best_d     = best_q;
        node_d     = node_q;
        clus_id_d  = clus_id_q;
        addr_d     = addr_q;
        nbr_clus_d = nbr_clus_q;
        hops_d     = hops_q;
        done_d     = 1'b0;
        data_d     = data_q;
        base_s     = base_addr(act_q);
        rd_d       = {mem[addr_q + 10'd1], mem[addr_q]};
        case (state_q)
            IDLE: begin
                if (done_prev) begin
                    state_d   = A_CLUS;
                    act_d     = _action;
                    best_d    = _besthop;
                    node_d    = MY_NODE_ID;
                    clus_id_d = MY_CLUSTER_ID;
                end else begin
                    state_d = IDLE;
                end
            end
            A_CLUS: begin
                addr_d  = base_s;
                state_d = A_HOPS;
            end
            A_HOPS: begin
                addr_d  = base_s + 10'd2;
                state_d = A_Q;
            end
            A_Q: begin
                addr_d     = base_s + 10'd6;
                nbr_clus_d = rd_q;
                state_d    = CALC;
            end
            CALC: begin
                hops_d  = rd_q;
                state_d = DONE;
            end
            DONE: begin
                // First DONE edge always reports; afterwards done follows done_prev.
                if (!done_q) begin
                    data_d = result_s;
                end else begin
                    data_d = data_q;
                end
                done_d = !done_q || done_prev;
                if (done_prev) begin
                    state_d = DONE;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state_q    <= IDLE;
            act_q      <= 16'h0000;
            best_q     <= 16'h0000;
            node_q     <= 16'h0000;
            clus_id_q  <= 16'h0000;
            addr_q     <= 10'h000;
            rd_q       <= 16'h0000;
            nbr_clus_q <= 16'h0000;
            hops_q     <= 16'h0000;
            done_q     <= 1'b0;
            data_q     <= 16'h0000;
        end else begin
            state_q    <= state_d;
            act_q      <= act_d;
            best_q     <= best_d;
            node_q     <= node_d;
            clus_id_q  <= clus_id_d;
            addr_q     <= addr_d;
            rd_q       <= rd_d;
            nbr_clus_q <= nbr_clus_d;
            hops_q     <= hops_d;
            done_q     <= done_d;
            data_q     <= data_d;
        end
    end

    assign address      = {6'b000000, addr_q};
    assign done_reward  = done_q;
    assign new_data_out = data_q;

endmodule

// File: tb/tb_reward_mem.sv
// Directed testbench for reward_mem with hand-computed expected results.
module tb_reward_mem;

    logic        clock = 1'b0;
    logic        nreset;
    logic [15:0] act_i;
    logic [15:0] best_i;
    logic [15:0] my_node;
    logic [15:0] my_clus;
    logic        done_prev;
    logic        wr_en;
    logic [9:0]  wr_addr;
    logic [15:0] mem_data_in;
    logic [15:0] address;
    logic        done_reward;
    logic [15:0] new_data_out;

    int n_vec = 0;
    int n_bad = 0;

    reward_mem dut (
        .clock         (clock),
        .nreset        (nreset),
        ._action       (act_i),
        ._besthop      (best_i),
        .MY_NODE_ID    (my_node),
        .MY_CLUSTER_ID (my_clus),
        .done_prev     (done_prev),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .mem_data_in   (mem_data_in),
        .address       (address),
        .done_reward   (done_reward),
        .new_data_out  (new_data_out)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [9:0] a, input logic [15:0] d);
        wr_en       = 1'b1;
        wr_addr     = a;
        mem_data_in = d;
        step();
        wr_en       = 1'b0;
    endtask

    task automatic preload(input logic [6:0] n, input logic [15:0] clus,
                           input logic [15:0] hops, input logic [15:0] q);
        logic [9:0] b;
        b = 10'h100 + {n, 3'b000};
        wr(b, clus);
        wr(b + 10'd2, hops);
        wr(b + 10'd4, 16'h0000);
        wr(b + 10'd6, q);
    endtask

    // One computation: E0 samples done_prev, result expected after E5.
    task automatic run(input string tag, input logic [9:0] base, input logic [15:0] exp,
                       input bit drop_early, input int hold);
        done_prev = 1'b1;
        step();
        if (drop_early) done_prev = 1'b0;
        act_i   = act_i ^ 16'h0055;
        best_i  = best_i ^ 16'h00AA;
        my_node = my_node ^ 16'h0001;
        my_clus = my_clus ^ 16'h0001;
        step();
        check({tag, "_addr_clus"}, address, {6'b000000, base});
        step();
        check({tag, "_addr_hops"}, address, {6'b000000, base + 10'd2});
        step();
        check({tag, "_addr_q"}, address, {6'b000000, base + 10'd6});
        step();
        check({tag, "_done_early"}, {15'd0, done_reward}, 16'h0000);
        step();
        check({tag, "_done"}, {15'd0, done_reward}, 16'h0001);
        check({tag, "_data"}, new_data_out, exp);
        for (int i = 0; i < hold; i++) begin
            step();
            check({tag, "_hold_done"}, {15'd0, done_reward}, 16'h0001);
            check({tag, "_hold_data"}, new_data_out, exp);
        end
        done_prev = 1'b0;
        step();
        check({tag, "_done_drop"}, {15'd0, done_reward}, 16'h0000);
        check({tag, "_addr_held"}, address, {6'b000000, base + 10'd6});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        nreset      = 1'b0;
        act_i       = 16'h0000;
        best_i      = 16'h0000;
        my_node     = 16'h0000;
        my_clus     = 16'h0000;
        done_prev   = 1'b0;
        wr_en       = 1'b0;
        wr_addr     = 10'h000;
        mem_data_in = 16'h0000;
        #2;
        check("rst_addr", address, 16'h0000);
        check("rst_done", {15'd0, done_reward}, 16'h0000);
        check("rst_data", new_data_out, 16'h0000);
        step();
        nreset = 1'b1;
        step();

        preload(7'd5, 16'd3, 16'd2, 16'd100);
        preload(7'd6, 16'd1, 16'd1, 16'd50);
        preload(7'd3, 16'd0, 16'd0, 16'd10);
        preload(7'h7F, 16'd3, 16'hFFFF, 16'h0100);

        act_i = 16'd5; best_i = 16'd6; my_node = 16'd3; my_clus = 16'd3;
        run("basic", 10'h128, 16'd100, 1'b0, 0);

        act_i = 16'd6; best_i = 16'd6; my_node = 16'd3; my_clus = 16'd3;
        run("besthop", 10'h130, 16'd53, 1'b0, 0);

        act_i = 16'd3; best_i = 16'd6; my_node = 16'd3; my_clus = 16'd3;
        run("self", 10'h118, 16'hFFFA, 1'b0, 0);

        act_i = 16'h0083; best_i = 16'd6; my_node = 16'd3; my_clus = 16'd3;
        run("alias", 10'h118, 16'd10, 1'b0, 0);

        act_i = 16'h00FF; best_i = 16'd6; my_node = 16'd3; my_clus = 16'd3;
        run("wrap_rsat", 10'h0F8, 16'h8100, 1'b0, 0);

        preload(7'd5, 16'd3, 16'd0, 16'h7FFE);
        act_i = 16'd5; best_i = 16'd5; my_node = 16'd3; my_clus = 16'd3;
        run("sat_hi", 10'h128, 16'h7FFF, 1'b0, 0);

        preload(7'd5, 16'd3, 16'd200, 16'h8002);
        act_i = 16'd5; best_i = 16'd5; my_node = 16'd3; my_clus = 16'd3;
        run("sat_lo_drop", 10'h128, 16'h8000, 1'b1, 0);
        step();
        check("drop_idle", {15'd0, done_reward}, 16'h0000);

        preload(7'd5, 16'd3, 16'd2, 16'd100);
        act_i = 16'd5; best_i = 16'd6; my_node = 16'd3; my_clus = 16'd3;
        run("hold", 10'h128, 16'd100, 1'b0, 20);

        act_i = 16'd6; best_i = 16'd6;
        done_prev = 1'b1;
        step();
        step();
        check("pre_rst_addr", address, 16'h0130);
        nreset = 1'b0;
        #1;
        check("mid_rst_addr", address, 16'h0000);
        check("mid_rst_done", {15'd0, done_reward}, 16'h0000);
        check("mid_rst_data", new_data_out, 16'h0000);
        #2;
        nreset = 1'b1;
        act_i = 16'd5; best_i = 16'd6; my_node = 16'd3; my_clus = 16'd3;
        run("after_rst", 10'h128, 16'd100, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/reward_mem.md
REWARD_MEM -- requirements
Module: reward_mem

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset, with ports named clock and nreset.
REQ-002 clock  input  1  rising-edge clock for all state, memory and outputs.
REQ-003 nreset  input  1  asynchronous active-low reset.
REQ-004 _action  input  16  candidate next-hop node ID being rewarded.
REQ-005 _besthop  input  16  current best next-hop node ID.
REQ-006 MY_NODE_ID  input  16  ID of this node.
REQ-007 MY_CLUSTER_ID  input  16  cluster ID of this node.
REQ-008 done_prev  input  1  start request, level-sensitive, from the previous pipeline stage.
REQ-009 wr_en  input  1  memory preload write enable.
REQ-010 wr_addr  input  10  memory preload byte address.
REQ-011 mem_data_in  input  16  memory preload word.
REQ-012 address  output  16  current memory read address; upper 6 bits are always 0.
REQ-013 done_reward  output  1  result valid / stage complete.
REQ-014 new_data_out  output  16  updated signed Q-value for _action.

Function
REQ-015 The memory SHALL be 1024 x 8-bit, byte-addressed, and 16-bit little-endian.
REQ-016 A memory write SHALL occur on the rising clock edge when wr_en=1, storing mem[wr_addr]=mem_data_in[7:0] and mem[wr_addr+1]=mem_data_in[15:8], with addresses taken mod 1024.
REQ-017 A memory read SHALL be synchronous with 1-cycle latency: the read word is {mem[address+1], mem[address]}, sampled at the edge after address is presented.
REQ-018 Memory contents SHALL NOT be cleared by nreset.
REQ-019 If a write and a read hit the same byte in the same cycle, the read SHALL return the old data.
REQ-020 The neighbour record for node n SHALL occupy base(n) = (0x100 + 8*n[6:0]) mod 1024, laid out as: +0 cluster ID, +2 hop count (unsigned), +4 energy (unused), +6 Q-value (signed).
REQ-021 The FSM SHALL have the states IDLE, A_CLUS, A_HOPS, A_Q, CALC and DONE.
REQ-022 IDLE SHALL move to A_CLUS on an edge where done_prev=1.
REQ-023 A_CLUS SHALL present base(_action)+0.
REQ-024 A_HOPS SHALL present base(_action)+2.
REQ-025 A_Q SHALL present base(_action)+4+2 and latch the cluster word.
REQ-026 CALC SHALL latch the hop count and Q-value and register new_data_out.
REQ-027 DONE SHALL assert done_reward.
REQ-028 A_CLUS through CALC SHALL each last 1 cycle, giving done_reward=1 on the 5th rising edge after the edge that sampled done_prev=1.
REQ-029 DONE SHALL hold done_reward=1 and new_data_out stable while done_prev=1, and SHALL return to IDLE on the first edge with done_prev=0, dropping done_reward.
REQ-030 There SHALL be exactly one computation per done_prev high period.
REQ-031 _action, _besthop, MY_NODE_ID and MY_CLUSTER_ID SHALL be sampled on the IDLE->A_CLUS edge, and later changes SHALL NOT affect the in-flight result.
REQ-032 Reward R (signed 16-bit) SHALL be -16 if _action == MY_NODE_ID (full 16-bit compare).
REQ-033 Otherwise, R SHALL be (_action==_besthop ? 4 : 0) + (cluster==MY_CLUSTER_ID ? 2 : 0) - hops, where hops is zero-extended and the subtraction is saturating.
REQ-034 new_data_out SHALL be Q + R computed in 17 bits and saturated to [0x8000, 0x7FFF].
REQ-035 Dropping done_prev before DONE SHALL NOT abort the computation; it completes, pulses done_reward for 1 cycle, then returns to IDLE.
REQ-036 In IDLE and DONE, address SHALL hold its last value.

Reset
REQ-037 When nreset=0, the block SHALL immediately set state=IDLE, done_reward=0, new_data_out=0, address=0 and clear all latched operands.
REQ-038 Reset SHALL abort any in-flight computation, including one in progress mid-operation.
REQ-039 After nreset rises with done_prev already 1, a new computation SHALL start on the first edge.

Verification
REQ-040 Setup: preload node 5 = {clus 3, hops 2, Q 100}; MY_NODE_ID=3, MY_CLUSTER_ID=3, _action=5, _besthop=6; raise done_prev -> address sequence 0x128, 0x12A, 0x12E, then new_data_out=100 and done_reward=1 five edges after start.
REQ-041 Preload node 6 = {clus 1, hops 1, Q 50}; _action=6, _besthop=6 -> new_data_out=53.
REQ-042 _action=3 (self), node 3 Q=10 -> new_data_out=0xFFFA (-6).
REQ-043 Node 5 Q=0x7FFE, hops=0, cluster match, _besthop=5 -> new_data_out=0x7FFF (saturation); Q=0x8002, hops=200 -> 0x8000.
REQ-044 Hold done_prev=1 for 20 cycles -> single computation, done_reward held; drop done_prev -> IDLE next edge.
REQ-045 Pulse nreset low during A_HOPS -> outputs immediately 0; with done_prev=1, recompute yields the same value as REQ-040 after 5 edges.
